conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
- Autonomous sequencer that sits directly upstream of core.
- Generates inst_w, X_MEM controls (CEN/WEN/A), kij and readout_start for one full 3x3 convolution pass: 9 kij iterations of weight load, activation feed and PSUM drain, then the ReLU wait and readout trigger.
- While idle, passes host X_MEM writes through so activations and weights can be preloaded.

Parameters:
- col, 8, array columns = weight words per kij
- len_nij, 36, activation words fed per kij
- len_kij, 9, kernel positions
- addr_bw, 11, X_MEM address width
- act_base, 0, activation base address
- wgt_base, 1024, weight base; kij k occupies wgt_base+k*col .. +col-1
- clr_cycles, 10, core reset pulse length per kij
- drain_cycles, 30, PSUM flush cycles after feed
- relu_cycles, 20, wait after last kij before readout

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle request to run a pass
- abort  in  1  synchronous abort
- host_cen  in  1  host X_MEM chip enable (active-low)
- host_wen  in  1  host X_MEM write enable (active-low)
- host_a  in  addr_bw  host X_MEM address
- inst_w  out  2  to core: 00 idle, 01 weight load, 10 activation feed
- cen_xmem  out  1  to core
- wen_xmem  out  1  to core
- a_xmem  out  addr_bw  to core
- kij  out  4  to core SFU
- core_rst  out  1  active-high reset to core array
- readout_start  out  1  one-cycle pulse to core
- busy  out  1  pass in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- All sequencer state is registered. Outputs decode from state/counter registers only; no input-to-output path except the host pass-through in IDLE.
- Reset (reset=0, async): state IDLE, counters 0. Outputs: inst_w=00, cen_xmem=1, wen_xmem=1, a_xmem=0, kij=0, core_rst=0, readout_start=0, busy=0, done=0. Host pass-through resumes on the first edge after release.
- IDLE: cen_xmem/wen_xmem/a_xmem = host_cen/host_wen/host_a; inst_w=00. start=1 at a posedge moves to CLR with kij=0; busy rises the same edge.
- CLR (clr_cycles): core_rst=1, cen=1, wen=1, inst_w=00. Goes to WLOAD.
- WLOAD (col cycles, t=0..col-1): inst_w=01, cen=0, wen=1, a=wgt_base+kij*col+t. Goes to GAP.
- GAP (1 cycle): inst_w=00, cen=1. Goes to XFEED.
- XFEED (len_nij cycles, t=0..len_nij-1): inst_w=10, cen=0, wen=1, a=act_base+t. Goes to DRAIN.
- DRAIN (drain_cycles): inst_w=00, cen=1.
  - If kij<len_kij-1: kij+=1 and go to CLR.
  - Else go to RELU.
- RELU (relu_cycles): outputs idle, kij holds len_kij-1. Goes to READ.
- READ (1 cycle): readout_start=1. Goes to DONE.
- DONE (1 cycle): done=1, busy=0. Goes to IDLE.
- Cycles per kij = clr_cycles+col+1+len_nij+drain_cycles = 85 at defaults.
- Total from start edge to readout_start = 9*85+20 = 785 cycles; done follows 1 cycle later.
- Address arithmetic is addr_bw bits, modulo 2^addr_bw. wgt_base+len_kij*col must not exceed 2^addr_bw (checked by assertion).
- Boundary conditions:
  - start while busy: ignored.
  - start and abort in the same IDLE cycle: abort wins, stay IDLE.
  - abort while busy: next state IDLE, no done pulse, kij reset to 0.
  - Host port changes while busy: ignored.
  - Async reset mid-pass: immediate return to reset values, no done pulse.
  - Terminal counts: each phase counter loads (length-1) on entry and advances on the zero flag. The phase's last cycle still drives its own address.

Decomposition:
- Package conv_seq_pkg holds:
  - state enum: IDLE, CLR, WLOAD, GAP, XFEED, DRAIN, RELU, READ, DONE
  - inst encodings: INST_IDLE=2'b00, INST_WLOAD=2'b01, INST_XFEED=2'b10
  - counter width function clog2 of max phase length
- One sub-module, seq_phase_cnt: loadable down-counter with zero flag, shared by all phases. The FSM and address generation stay in conv_seq_ctrl.

Test Plan:
- Reset held low 5 cycles with host_cen=0 -> all outputs at reset values. After release, cen_xmem follows host_cen=0 and a_xmem follows host_a=0x005 on the next cycle.
- start pulse, defaults -> core_rst high for 10 cycles. Then inst_w=01 for 8 cycles with a_xmem=1024..1031, then 1 cycle inst_w=00, then inst_w=10 for 36 cycles with a_xmem=0..35, then 30 idle cycles.
- Full pass -> kij steps 0..8. kij=8 weight addresses are 1088..1095. readout_start is high exactly at cycle 785 after the start edge, done at 786, and busy is low from 786.
- start pulsed again at cycle 200 of a pass -> no effect; total timing is unchanged.
- abort during kij=3 XFEED -> IDLE next cycle, busy=0, no done, kij=0, host pass-through restored.
- reset asserted during DRAIN of kij=5 -> outputs at reset values immediately (asynchronously). A new start after release runs a full 785-cycle pass from kij=0.

Source files
------------

// File: rtl/conv_seq_ctrl_pkg.sv
// Shared types and defaults for the 3x3 convolution pass sequencer.
package conv_seq_pkg;

    // Sequencer states, in pass order
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        CLR   = 4'd1,
        WLOAD = 4'd2,
        GAP   = 4'd3,
        XFEED = 4'd4,
        DRAIN = 4'd5,
        RELU  = 4'd6,
        READ  = 4'd7,
        DONE  = 4'd8
    } seq_state_e;

    // Instruction encodings presented to the core
    localparam logic [1:0] INST_IDLE  = 2'b00;
    localparam logic [1:0] INST_WLOAD = 2'b01;
    localparam logic [1:0] INST_XFEED = 2'b10;

    // Default geometry and phase lengths
    localparam int DEF_COL          = 8;
    localparam int DEF_LEN_NIJ      = 36;
    localparam int DEF_LEN_KIJ      = 9;
    localparam int DEF_ADDR_BW      = 11;
    localparam int DEF_ACT_BASE     = 0;
    localparam int DEF_WGT_BASE     = 1024;
    localparam int DEF_CLR_CYCLES   = 10;
    localparam int DEF_DRAIN_CYCLES = 30;
    localparam int DEF_RELU_CYCLES  = 20;

    // Longest of the five counted phases
    function automatic int max_phase(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // Bits needed to hold (max_len-1), never less than one
    function automatic int cnt_width(input int max_len);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< w) < max_len) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Host-side and core-side signal bundle of the convolution sequencer.
interface conv_seq_ctrl_if
    import conv_seq_pkg::*;
#(
    parameter int ADDR_BW = DEF_ADDR_BW
) ();
    logic               start;
    logic               abort;
    logic               host_cen;
    logic               host_wen;
    logic [ADDR_BW-1:0] host_a;
    logic [1:0]         inst_w;
    logic               cen_xmem;
    logic               wen_xmem;
    logic [ADDR_BW-1:0] a_xmem;
    logic [3:0]         kij;
    logic               core_rst;
    logic               readout_start;
    logic               busy;
    logic               done;

    // Host / controlling side
    modport master (
        output start, abort, host_cen, host_wen, host_a,
        input  inst_w, cen_xmem, wen_xmem, a_xmem, kij, core_rst,
               readout_start, busy, done
    );

    // Sequencer side
    modport slave (
        input  start, abort, host_cen, host_wen, host_a,
        output inst_w, cen_xmem, wen_xmem, a_xmem, kij, core_rst,
               readout_start, busy, done
    );
endinterface

// File: rtl/conv_seq_ctrl_chk.sv
// Property checks for the convolution sequencer outputs and parameters.
module conv_seq_ctrl_chk #(
    parameter int ADDR_BW  = 11,
    parameter int WGT_BASE = 1024,
    parameter int COL      = 8,
    parameter int LEN_KIJ  = 9
) (
    input logic       clk,
    input logic       rst_n,
    input logic       busy,
    input logic       done,
    input logic       readout_start,
    input logic [3:0] kij
);
    localparam longint WGT_END    = longint'(WGT_BASE) + longint'(LEN_KIJ) * longint'(COL);
    localparam longint ADDR_SPACE = longint'(1) << ADDR_BW;
    localparam bit     RANGE_OK   = (WGT_END <= ADDR_SPACE);
    localparam logic [3:0] KIJ_LAST = 4'(LEN_KIJ - 1);

    a_wgt_range:   assert property (@(posedge clk) disable iff (!rst_n) RANGE_OK);
    a_done_idle:   assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);
    a_read_busy:   assert property (@(posedge clk) disable iff (!rst_n) readout_start |-> busy);
    a_kij_range:   assert property (@(posedge clk) disable iff (!rst_n) kij <= KIJ_LAST);
endmodule

// File: rtl/conv_seq_ctrl_seq_phase_cnt.sv
// Loadable down-counter with zero flag; times every sequencer phase.
module seq_phase_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: load wins, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == {W{1'b0}});
endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer driving one full 3x3 convolution pass into the core, with
// host X_MEM pass-through while idle. All outputs are flops.
module conv_seq_ctrl
    import conv_seq_pkg::*;
#(
    parameter int COL          = DEF_COL,
    parameter int LEN_NIJ      = DEF_LEN_NIJ,
    parameter int LEN_KIJ      = DEF_LEN_KIJ,
    parameter int ADDR_BW      = DEF_ADDR_BW,
    parameter int ACT_BASE     = DEF_ACT_BASE,
    parameter int WGT_BASE     = DEF_WGT_BASE,
    parameter int CLR_CYCLES   = DEF_CLR_CYCLES,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int RELU_CYCLES  = DEF_RELU_CYCLES
) (
    input logic           clk,
    input logic           reset,
    conv_seq_ctrl_if.slave bus
);
    localparam int CNT_W = cnt_width(max_phase(CLR_CYCLES, COL, LEN_NIJ,
                                               DRAIN_CYCLES, RELU_CYCLES));

    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] WLOAD_LAST = CNT_W'(COL - 1);
    localparam logic [CNT_W-1:0] XFEED_LAST = CNT_W'(LEN_NIJ - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELU_LAST  = CNT_W'(RELU_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_SHOT   = {CNT_W{1'b0}};

    localparam logic [ADDR_BW-1:0] WGT_BASE_A = ADDR_BW'(WGT_BASE);
    localparam logic [ADDR_BW-1:0] ACT_BASE_A = ADDR_BW'(ACT_BASE);
    localparam logic [ADDR_BW-1:0] COL_A      = ADDR_BW'(COL);
    localparam logic [ADDR_BW-1:0] ADDR_ONE   = ADDR_BW'(1);
    localparam logic [3:0]         KIJ_LAST   = 4'(LEN_KIJ - 1);

    seq_state_e         state_q, state_d;
    logic [3:0]         kij_q, kij_d;
    logic [1:0]         inst_w_q, inst_w_d;
    logic               cen_q, cen_d;
    logic               wen_q, wen_d;
    logic [ADDR_BW-1:0] a_q, a_d;
    logic               core_rst_q, core_rst_d;
    logic               readout_q, readout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cnt_load_s;
    logic [CNT_W-1:0]   cnt_load_val_s;
    logic [CNT_W-1:0]   cnt_s;
    logic               cnt_zero_s;
    logic [ADDR_BW-1:0] wgt_start_s;

    seq_phase_cnt #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .cnt      (cnt_s),
        .zero     (cnt_zero_s)
    );

    // Next state, kij and phase-counter reload; abort overrides everything
    always_comb begin
        state_d        = state_q;
        kij_d          = kij_q;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = ONE_SHOT;
        if (bus.abort) begin
            state_d    = IDLE;
            kij_d      = 4'd0;
            cnt_load_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d        = CLR;
                        kij_d          = 4'd0;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = CLR_LAST;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CLR: begin
                    if (cnt_zero_s) begin
                        state_d        = WLOAD;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = WLOAD_LAST;
                    end else begin
                        state_d = CLR;
                    end
                end
                WLOAD: begin
                    if (cnt_zero_s) begin
                        state_d        = GAP;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = ONE_SHOT;
                    end else begin
                        state_d = WLOAD;
                    end
                end
                GAP: begin
                    if (cnt_zero_s) begin
                        state_d        = XFEED;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = XFEED_LAST;
                    end else begin
                        state_d = GAP;
                    end
                end
                XFEED: begin
                    if (cnt_zero_s) begin
                        state_d        = DRAIN;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = DRAIN_LAST;
                    end else begin
                        state_d = XFEED;
                    end
                end
                DRAIN: begin
                    if (cnt_zero_s && (kij_q < KIJ_LAST)) begin
                        state_d        = CLR;
                        kij_d          = kij_q + 4'd1;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = CLR_LAST;
                    end else if (cnt_zero_s) begin
                        state_d        = RELU;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = RELU_LAST;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                RELU: begin
                    if (cnt_zero_s) begin
                        state_d    = READ;
                        cnt_load_s = 1'b1;
                    end else begin
                        state_d = RELU;
                    end
                end
                READ: begin
                    state_d    = DONE;
                    cnt_load_s = 1'b1;
                end
                DONE: begin
                    state_d    = IDLE;
                    cnt_load_s = 1'b1;
                end
                default: begin
                    state_d    = IDLE;
                    kij_d      = 4'd0;
                    cnt_load_s = 1'b1;
                end
            endcase
        end
    end

    assign wgt_start_s = WGT_BASE_A + (ADDR_BW'(kij_d) * COL_A);

    // Output decode from the state being entered so outputs line up with it
    always_comb begin
        inst_w_d   = INST_IDLE;
        cen_d      = 1'b1;
        wen_d      = 1'b1;
        a_d        = a_q;
        core_rst_d = 1'b0;
        readout_d  = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        case (state_d)
            IDLE: begin
                cen_d  = bus.host_cen;
                wen_d  = bus.host_wen;
                a_d    = bus.host_a;
                busy_d = 1'b0;
            end
            CLR: begin
                core_rst_d = 1'b1;
            end
            WLOAD: begin
                inst_w_d = INST_WLOAD;
                cen_d    = 1'b0;
                if (state_q == WLOAD) begin
                    a_d = a_q + ADDR_ONE;
                end else begin
                    a_d = wgt_start_s;
                end
            end
            XFEED: begin
                inst_w_d = INST_XFEED;
                cen_d    = 1'b0;
                if (state_q == XFEED) begin
                    a_d = a_q + ADDR_ONE;
                end else begin
                    a_d = ACT_BASE_A;
                end
            end
            GAP, DRAIN, RELU: begin
                inst_w_d = INST_IDLE;
            end
            READ: begin
                readout_d = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, kij and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            kij_q      <= 4'd0;
            inst_w_q   <= INST_IDLE;
            cen_q      <= 1'b1;
            wen_q      <= 1'b1;
            a_q        <= {ADDR_BW{1'b0}};
            core_rst_q <= 1'b0;
            readout_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kij_q      <= kij_d;
            inst_w_q   <= inst_w_d;
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            a_q        <= a_d;
            core_rst_q <= core_rst_d;
            readout_q  <= readout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.inst_w        = inst_w_q;
    assign bus.cen_xmem      = cen_q;
    assign bus.wen_xmem      = wen_q;
    assign bus.a_xmem        = a_q;
    assign bus.kij           = kij_q;
    assign bus.core_rst      = core_rst_q;
    assign bus.readout_start = readout_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

    conv_seq_ctrl_chk #(
        .ADDR_BW  (ADDR_BW),
        .WGT_BASE (WGT_BASE),
        .COL      (COL),
        .LEN_KIJ  (LEN_KIJ)
    ) u_chk (
        .clk           (clk),
        .rst_n         (reset),
        .busy          (busy_q),
        .done          (done_q),
        .readout_start (readout_q),
        .kij           (kij_q)
    );
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl: an independent per-cycle model of a
// pass is queued at start and compared on each falling edge.
module tb_conv_seq_ctrl;
    localparam int ADDR_BW = 11;
    localparam int PASS_LEN = 9 * 85 + 20 + 2;   // cycles 0..786

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_seq_ctrl_if #(.ADDR_BW(ADDR_BW)) bus ();

    conv_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0]  inst;
        logic        cen;
        logic        wen;
        logic [10:0] a;
        logic        chk_a;
        logic [3:0]  kij;
        logic        crst;
        logic        rd;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    exp_t model_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sb_idx   = 0;
    logic bad;

    function automatic exp_t mk(input logic [1:0] inst, input logic cen, input logic wen,
                                input logic [10:0] a, input logic chk_a, input logic [3:0] k,
                                input logic crst, input logic rd, input logic busy,
                                input logic done);
        exp_t x;
        x.inst = inst; x.cen = cen; x.wen = wen; x.a = a; x.chk_a = chk_a;
        x.kij = k; x.crst = crst; x.rd = rd; x.busy = busy; x.done = done;
        return x;
    endfunction

    // Expected output of every cycle after the start edge
    function automatic void build_model();
        model_q.delete();
        for (int k = 0; k < 9; k++) begin
            for (int t = 0; t < 10; t++) model_q.push_back(mk(2'b00, 1'b1, 1'b1, 11'd0, 1'b0, 4'(k), 1'b1, 1'b0, 1'b1, 1'b0));
            for (int t = 0; t < 8; t++)  model_q.push_back(mk(2'b01, 1'b0, 1'b1, 11'(1024 + k * 8 + t), 1'b1, 4'(k), 1'b0, 1'b0, 1'b1, 1'b0));
            model_q.push_back(mk(2'b00, 1'b1, 1'b1, 11'd0, 1'b0, 4'(k), 1'b0, 1'b0, 1'b1, 1'b0));
            for (int t = 0; t < 36; t++) model_q.push_back(mk(2'b10, 1'b0, 1'b1, 11'(t), 1'b1, 4'(k), 1'b0, 1'b0, 1'b1, 1'b0));
            for (int t = 0; t < 30; t++) model_q.push_back(mk(2'b00, 1'b1, 1'b1, 11'd0, 1'b0, 4'(k), 1'b0, 1'b0, 1'b1, 1'b0));
        end
        for (int t = 0; t < 20; t++) model_q.push_back(mk(2'b00, 1'b1, 1'b1, 11'd0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0));
        model_q.push_back(mk(2'b00, 1'b1, 1'b1, 11'd0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0));
        model_q.push_back(mk(2'b00, 1'b1, 1'b1, 11'd0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1));
    endfunction

    // Queue the first n model cycles, then n_idle pass-through cycles
    task automatic push_pass(input int n, input int n_idle, input logic hc, input logic hw,
                             input logic [10:0] ha, input logic [3:0] idle_kij);
        build_model();
        sb_idx = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(model_q[i]);
        for (int i = 0; i < n_idle; i++)
            exp_q.push_back(mk(2'b00, hc, hw, ha, 1'b1, idle_kij, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // Scoreboard: compare one queued cycle per falling edge
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            bad = (bus.inst_w !== e.inst) || (bus.cen_xmem !== e.cen) || (bus.wen_xmem !== e.wen)
                || (e.chk_a && (bus.a_xmem !== e.a)) || (bus.kij !== e.kij)
                || (bus.core_rst !== e.crst) || (bus.readout_start !== e.rd)
                || (bus.busy !== e.busy) || (bus.done !== e.done);
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL scoreboard cycle %0d: got inst=%b cen=%b wen=%b a=%0d kij=%0d rst=%b rd=%b busy=%b done=%b, expected inst=%b cen=%b wen=%b a=%0d(chk=%b) kij=%0d rst=%b rd=%b busy=%b done=%b",
                         sb_idx, bus.inst_w, bus.cen_xmem, bus.wen_xmem, bus.a_xmem, bus.kij,
                         bus.core_rst, bus.readout_start, bus.busy, bus.done,
                         e.inst, e.cen, e.wen, e.a, e.chk_a, e.kij, e.crst, e.rd, e.busy, e.done);
            end
            sb_idx++;
        end
    end

    task automatic start_pass();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s drain: %0d entries left, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.host_cen = 1'b0; bus.host_wen = 1'b0; bus.host_a = 11'h005;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.inst_w !== 2'b00) begin n_fail++; $display("FAIL reset inst_w: got %b expected 00", bus.inst_w); end
        n_checks++; if (bus.cen_xmem !== 1'b1) begin n_fail++; $display("FAIL reset cen: got %b expected 1", bus.cen_xmem); end
        n_checks++; if (bus.wen_xmem !== 1'b1) begin n_fail++; $display("FAIL reset wen: got %b expected 1", bus.wen_xmem); end
        n_checks++; if (bus.a_xmem !== 11'd0) begin n_fail++; $display("FAIL reset a: got %0d expected 0", bus.a_xmem); end
        n_checks++; if (bus.kij !== 4'd0) begin n_fail++; $display("FAIL reset kij: got %0d expected 0", bus.kij); end
        n_checks++; if ({bus.core_rst, bus.readout_start, bus.busy, bus.done} !== 4'b0000) begin
            n_fail++; $display("FAIL reset flags: got %b expected 0000", {bus.core_rst, bus.readout_start, bus.busy, bus.done}); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.cen_xmem !== 1'b0) begin n_fail++; $display("FAIL passthru cen: got %b expected 0", bus.cen_xmem); end
        n_checks++; if (bus.wen_xmem !== 1'b0) begin n_fail++; $display("FAIL passthru wen: got %b expected 0", bus.wen_xmem); end
        n_checks++; if (bus.a_xmem !== 11'h005) begin n_fail++; $display("FAIL passthru a: got %0d expected 5", bus.a_xmem); end
    endtask

    task automatic test_full_pass();
        start_pass();
        push_pass(PASS_LEN, 2, 1'b0, 1'b0, 11'h005, 4'd8);
        wait_drain("full_pass");
    endtask

    task automatic test_start_while_busy();
        start_pass();
        push_pass(PASS_LEN, 2, 1'b1, 1'b1, 11'h7ff, 4'd8);
        repeat (199) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.host_cen = 1'b1; bus.host_wen = 1'b1; bus.host_a = 11'h7ff;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_drain("start_while_busy");
    endtask

    task automatic test_abort();
        @(negedge clk);
        bus.host_cen = 1'b0; bus.host_wen = 1'b1; bus.host_a = 11'h0aa;
        start_pass();
        push_pass(290, 4, 1'b0, 1'b1, 11'h0aa, 4'd0);
        repeat (289) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        wait_drain("abort_xfeed");
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.abort = 1'b0;
        push_pass(0, 3, 1'b0, 1'b1, 11'h0aa, 4'd0);
        wait_drain("start_abort_idle");
    endtask

    task automatic test_reset_mid_pass();
        start_pass();
        push_pass(490, 0, 1'b0, 1'b1, 11'h0aa, 4'd0);
        repeat (490) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++; if ({bus.inst_w, bus.cen_xmem, bus.wen_xmem} !== 4'b0011) begin
            n_fail++; $display("FAIL midreset ctrl: got %b expected 0011", {bus.inst_w, bus.cen_xmem, bus.wen_xmem}); end
        n_checks++; if (bus.a_xmem !== 11'd0) begin n_fail++; $display("FAIL midreset a: got %0d expected 0", bus.a_xmem); end
        n_checks++; if (bus.kij !== 4'd0) begin n_fail++; $display("FAIL midreset kij: got %0d expected 0", bus.kij); end
        n_checks++; if ({bus.core_rst, bus.readout_start, bus.busy, bus.done} !== 4'b0000) begin
            n_fail++; $display("FAIL midreset flags: got %b expected 0000", {bus.core_rst, bus.readout_start, bus.busy, bus.done}); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start_pass();
        push_pass(PASS_LEN, 2, 1'b0, 1'b1, 11'h0aa, 4'd8);
        wait_drain("pass_after_reset");
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_start_while_busy();
        test_abort();
        test_reset_mid_pass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
